// File: rtl/flash_loader_if.sv
// rtl/flash_loader_if.sv - boot loader bus bundle: start/status, flash_serial control/data, RAM write port
//
// Signals:
//   in_start               start request (rising edge starts a load)
//   out_busy, out_done     load status
//   out_checksum           running checksum of loaded words
//   out_flash_enable/read/addr   control towards flash_serial
//   in_flash_data, in_flash_word_finished   data/strobe from flash_serial
//   out_mem_addr/data/write      RAM write port
// Modports: slave = loader side, master = sequencer/flash/RAM side.
interface flash_loader_if #(
    parameter int WORD_BITS     = 8,
    parameter int ADDRESS_WORDS = 2,
    parameter int MEM_ADDR_BITS = 8,
    parameter int CHK_BITS      = 16
);
    logic                                 in_start;
    logic                                 out_busy;
    logic                                 out_done;
    logic [CHK_BITS-1:0]                  out_checksum;
    logic                                 out_flash_enable;
    logic                                 out_flash_read;
    logic [WORD_BITS*ADDRESS_WORDS-1:0]   out_flash_addr;
    logic [WORD_BITS-1:0]                 in_flash_data;
    logic                                 in_flash_word_finished;
    logic [MEM_ADDR_BITS-1:0]             out_mem_addr;
    logic [WORD_BITS-1:0]                 out_mem_data;
    logic                                 out_mem_write;

    modport slave (
        input  in_start, in_flash_data, in_flash_word_finished,
        output out_busy, out_done, out_checksum, out_flash_enable, out_flash_read,
               out_flash_addr, out_mem_addr, out_mem_data, out_mem_write
    );

    modport master (
        output in_start, in_flash_data, in_flash_word_finished,
        input  out_busy, out_done, out_checksum, out_flash_enable, out_flash_read,
               out_flash_addr, out_mem_addr, out_mem_data, out_mem_write
    );
endinterface

// File: rtl/flash_loader.sv
// rtl/flash_loader.sv - copies NUM_WORDS flash words into boot RAM with a running checksum
//
// Ports:
//   in_clk   main clock
//   in_rst   asynchronous active-high reset
//   bus      flash_loader_if.slave: start/busy/done/checksum, flash_serial control and
//            data, RAM write port (addr/data/one-cycle write strobe)
module flash_loader #(
    parameter int                                 WORD_BITS        = 8,
    parameter int                                 ADDRESS_WORDS    = 2,
    parameter logic [WORD_BITS*ADDRESS_WORDS-1:0] FLASH_START_ADDR = '0,
    parameter int                                 NUM_WORDS        = 256,
    parameter int                                 MEM_ADDR_BITS    = 8,
    parameter int                                 CHK_BITS         = 16
) (
    input logic           in_clk,
    input logic           in_rst,
    flash_loader_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_READ,
        S_RELEASE,
        S_DONE
    } state_t;

    // One extra counter bit so a full 2^MEM_ADDR_BITS load never wraps.
    localparam logic [MEM_ADDR_BITS:0] LAST_IDX = (MEM_ADDR_BITS+1)'(NUM_WORDS - 1);
    localparam logic [MEM_ADDR_BITS:0] CNT_ONE  = (MEM_ADDR_BITS+1)'(1);

    state_t                   state;
    logic                     last_start;
    logic                     last_word_rdy;
    logic [MEM_ADDR_BITS:0]   counter;
    logic                     rel_cnt;
    logic                     busy;
    logic                     done;
    logic [CHK_BITS-1:0]      checksum;
    logic                     flash_enable;
    logic [MEM_ADDR_BITS-1:0] mem_addr;
    logic [WORD_BITS-1:0]     mem_data;
    logic                     mem_write;
    logic                     start_edge;
    logic                     word_edge;

    assign start_edge = bus.in_start & ~last_start;
    assign word_edge  = bus.in_flash_word_finished & ~last_word_rdy;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state         <= S_IDLE;
            last_start    <= 1'b0;
            last_word_rdy <= 1'b0;
            counter       <= '0;
            rel_cnt       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            checksum      <= '0;
            flash_enable  <= 1'b0;
            mem_addr      <= '0;
            mem_data      <= '0;
            mem_write     <= 1'b0;
        end else begin
            // Edge registers run every cycle; the Arm cycle therefore absorbs a
            // word_finished level that was already high before the load began.
            last_start    <= bus.in_start;
            last_word_rdy <= bus.in_flash_word_finished;
            mem_write     <= 1'b0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start_edge) begin
                        state        <= S_ARM;
                        counter      <= '0;
                        checksum     <= '0;
                        done         <= 1'b0;
                        busy         <= 1'b1;
                        flash_enable <= 1'b1;
                    end
                end
                S_ARM: begin
                    state <= S_READ;
                end
                S_READ: begin
                    if (word_edge) begin
                        mem_write <= 1'b1;
                        mem_addr  <= counter[MEM_ADDR_BITS-1:0];
                        mem_data  <= bus.in_flash_data;
                        checksum  <= checksum + CHK_BITS'(bus.in_flash_data);
                        counter   <= counter + CNT_ONE;
                        if (counter == LAST_IDX) begin
                            state        <= S_RELEASE;
                            flash_enable <= 1'b0;
                            rel_cnt      <= 1'b0;
                        end
                    end
                end
                S_RELEASE: begin
                    // Two cycles with enable low so flash_serial can deselect.
                    if (rel_cnt) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        rel_cnt <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.out_busy         = busy;
    assign bus.out_done         = done;
    assign bus.out_checksum     = checksum;
    assign bus.out_flash_enable = flash_enable;
    assign bus.out_flash_read   = 1'b1;
    assign bus.out_flash_addr   = FLASH_START_ADDR;
    assign bus.out_mem_addr     = mem_addr;
    assign bus.out_mem_data     = mem_data;
    assign bus.out_mem_write    = mem_write;
endmodule

// File: tb/tb_flash_loader.sv
// tb/tb_flash_loader.sv - scoreboard bench for flash_loader (4-word and 256-word instances)
module tb_flash_loader;
    logic in_clk;
    logic in_rst;

    flash_loader_if #(.WORD_BITS(8), .ADDRESS_WORDS(2), .MEM_ADDR_BITS(8), .CHK_BITS(16)) bus4 ();
    flash_loader_if #(.WORD_BITS(8), .ADDRESS_WORDS(2), .MEM_ADDR_BITS(8), .CHK_BITS(16)) bus256 ();

    flash_loader #(
        .WORD_BITS(8), .ADDRESS_WORDS(2), .FLASH_START_ADDR(16'h0000),
        .NUM_WORDS(4), .MEM_ADDR_BITS(8), .CHK_BITS(16)
    ) u_dut4 (
        .in_clk (in_clk),
        .in_rst (in_rst),
        .bus    (bus4)
    );

    flash_loader #(
        .WORD_BITS(8), .ADDRESS_WORDS(2), .FLASH_START_ADDR(16'h0000),
        .NUM_WORDS(256), .MEM_ADDR_BITS(8), .CHK_BITS(16)
    ) u_dut256 (
        .in_clk (in_clk),
        .in_rst (in_rst),
        .bus    (bus256)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt4 = 0;
    int wr_cnt256 = 0;
    int done_rise4 = 0;
    logic last_done4 = 1'b0;
    logic stale4 = 1'b0;
    logic [15:0] q4[$];
    logic [15:0] q256[$];

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Flash model: word_finished high for 2 cycles, low for 2 cycles; data for
    // the next address is presented on each rising edge.
    initial begin : flash_model4
        int cnt;
        logic [15:0] faddr;
        cnt = 0;
        faddr = 16'h0000;
        bus4.in_flash_data = 8'h00;
        bus4.in_flash_word_finished = 1'b0;
        forever begin
            @(negedge in_clk);
            if (!bus4.out_flash_enable) begin
                cnt = 0;
                faddr = bus4.out_flash_addr;
                bus4.in_flash_data = 8'h00;
                bus4.in_flash_word_finished = stale4;
            end else begin
                cnt++;
                if (cnt >= 2) begin
                    cnt = 0;
                    if (bus4.in_flash_word_finished) begin
                        bus4.in_flash_word_finished = 1'b0;
                    end else begin
                        bus4.in_flash_data = faddr[7:0] ^ 8'hA5;
                        faddr++;
                        bus4.in_flash_word_finished = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : flash_model256
        int cnt;
        cnt = 0;
        bus256.in_flash_data = 8'h00;
        bus256.in_flash_word_finished = 1'b0;
        forever begin
            @(negedge in_clk);
            if (!bus256.out_flash_enable) begin
                cnt = 0;
                bus256.in_flash_data = 8'h00;
                bus256.in_flash_word_finished = 1'b0;
            end else begin
                cnt++;
                if (cnt >= 2) begin
                    cnt = 0;
                    if (bus256.in_flash_word_finished) begin
                        bus256.in_flash_word_finished = 1'b0;
                    end else begin
                        bus256.in_flash_data = 8'hFF;
                        bus256.in_flash_word_finished = 1'b1;
                    end
                end
            end
        end
    end

    // Monitors: every strobe cycle pops one expected {addr,data}.
    always @(negedge in_clk) begin
        logic [15:0] e;
        if (bus4.out_mem_write === 1'b1) begin
            wr_cnt4++;
            if (q4.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL write4_unexpected: got addr %0h data %0h expected no write",
                         bus4.out_mem_addr, bus4.out_mem_data);
            end else begin
                e = q4.pop_front();
                check("write4", {bus4.out_mem_addr, bus4.out_mem_data}, {16'h0, e});
            end
        end
        if (bus4.out_done === 1'b1 && !last_done4) done_rise4++;
        last_done4 = (bus4.out_done === 1'b1);
    end

    always @(negedge in_clk) begin
        logic [15:0] e;
        if (bus256.out_mem_write === 1'b1) begin
            wr_cnt256++;
            if (q256.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL write256_unexpected: got addr %0h data %0h expected no write",
                         bus256.out_mem_addr, bus256.out_mem_data);
            end else begin
                e = q256.pop_front();
                check("write256", {bus256.out_mem_addr, bus256.out_mem_data}, {16'h0, e});
            end
        end
    end

    task automatic push4();
        for (int i = 0; i < 4; i++) begin
            logic [7:0] a;
            a = 8'(i);
            q4.push_back({a, a ^ 8'hA5});
        end
    endtask

    task automatic pulse_start4();
        @(negedge in_clk);
        bus4.in_start = 1'b1;
        @(negedge in_clk);
        bus4.in_start = 1'b0;
    endtask

    task automatic wait_done4(input int budget);
        int i;
        i = 0;
        while (bus4.out_done !== 1'b1 && i < budget) begin
            @(negedge in_clk);
            i++;
        end
        check("done4_within_budget", {31'h0, bus4.out_done}, 32'h1);
    endtask

    task automatic check_final4(input string tag);
        repeat (6) @(negedge in_clk);
        check({tag, "_done"}, {31'h0, bus4.out_done}, 32'h1);
        check({tag, "_busy"}, {31'h0, bus4.out_busy}, 32'h0);
        check({tag, "_enable"}, {31'h0, bus4.out_flash_enable}, 32'h0);
        check({tag, "_checksum"}, {16'h0, bus4.out_checksum}, 32'h0296);
        check({tag, "_queue_empty"}, q4.size(), 32'h0);
    endtask

    initial begin : stimulus
        int base;
        int i;
        in_rst = 1'b1;
        bus4.in_start = 1'b0;
        bus256.in_start = 1'b0;
        repeat (3) @(negedge in_clk);
        check("rst_busy", {31'h0, bus4.out_busy}, 32'h0);
        check("rst_done", {31'h0, bus4.out_done}, 32'h0);
        check("rst_checksum", {16'h0, bus4.out_checksum}, 32'h0);
        check("rst_enable", {31'h0, bus4.out_flash_enable}, 32'h0);
        check("rst_write", {31'h0, bus4.out_mem_write}, 32'h0);
        check("rst_mem_addr_data", {16'h0, bus4.out_mem_addr, bus4.out_mem_data}, 32'h0);
        check("flash_read_const", {31'h0, bus4.out_flash_read}, 32'h1);
        check("flash_addr_const", {16'h0, bus4.out_flash_addr}, 32'h0000);
        in_rst = 1'b0;
        repeat (2) @(negedge in_clk);

        // Basic 4-word load.
        base = wr_cnt4;
        push4();
        pulse_start4();
        check("busy_after_start", {31'h0, bus4.out_busy}, 32'h1);
        wait_done4(200);
        check_final4("basic");
        check("basic_writes", wr_cnt4 - base, 32'd4);

        // Stale high word_finished before start is not counted.
        stale4 = 1'b1;
        repeat (3) @(negedge in_clk);
        base = wr_cnt4;
        push4();
        pulse_start4();
        wait_done4(200);
        check_final4("stale");
        check("stale_writes", wr_cnt4 - base, 32'd4);
        stale4 = 1'b0;
        repeat (3) @(negedge in_clk);

        // Second start during Read is dropped; done asserts once.
        base = wr_cnt4;
        push4();
        pulse_start4();
        check("restart_done_cleared", {31'h0, bus4.out_done}, 32'h0);
        check("restart_checksum_cleared", {16'h0, bus4.out_checksum}, 32'h0);
        i = 0;
        while (wr_cnt4 < base + 1 && i < 100) begin
            @(negedge in_clk);
            i++;
        end
        check("first_write_seen", {31'h0, wr_cnt4 >= base + 1}, 32'h1);
        i = done_rise4;
        pulse_start4();
        wait_done4(200);
        check_final4("dbl_start");
        check("dbl_start_writes", wr_cnt4 - base, 32'd4);
        check("dbl_start_done_rises", done_rise4 - i, 32'd1);

        // Reset after 2 of 4 words.
        base = wr_cnt4;
        push4();
        pulse_start4();
        i = 0;
        while (wr_cnt4 < base + 2 && i < 100) begin
            @(negedge in_clk);
            i++;
        end
        check("two_writes_seen", wr_cnt4 - base, 32'd2);
        @(negedge in_clk);
        #2 in_rst = 1'b1;
        #1;
        check("async_rst_busy", {31'h0, bus4.out_busy}, 32'h0);
        check("async_rst_enable", {31'h0, bus4.out_flash_enable}, 32'h0);
        check("async_rst_checksum", {16'h0, bus4.out_checksum}, 32'h0);
        check("async_rst_done", {31'h0, bus4.out_done}, 32'h0);
        check("async_rst_mem", {15'h0, bus4.out_mem_write, bus4.out_mem_addr, bus4.out_mem_data}, 32'h0);
        q4.delete();
        @(negedge in_clk);
        in_rst = 1'b0;
        repeat (20) @(negedge in_clk);
        check("no_writes_after_rst", wr_cnt4 - base, 32'd2);
        check("idle_after_rst_done", {31'h0, bus4.out_done}, 32'h0);
        base = wr_cnt4;
        push4();
        pulse_start4();
        wait_done4(200);
        check_final4("after_rst");
        check("after_rst_writes", wr_cnt4 - base, 32'd4);

        // 256-word load of 0xFF: no address wrap, checksum 0xFF00.
        for (int k = 0; k < 256; k++) begin
            logic [7:0] a;
            a = 8'(k);
            q256.push_back({a, 8'hFF});
        end
        @(negedge in_clk);
        bus256.in_start = 1'b1;
        @(negedge in_clk);
        bus256.in_start = 1'b0;
        i = 0;
        while (bus256.out_done !== 1'b1 && i < 3000) begin
            @(negedge in_clk);
            i++;
        end
        check("done256_within_budget", {31'h0, bus256.out_done}, 32'h1);
        repeat (4) @(negedge in_clk);
        check("w256_writes", wr_cnt256, 32'd256);
        check("w256_checksum", {16'h0, bus256.out_checksum}, 32'hFF00);
        check("w256_busy", {31'h0, bus256.out_busy}, 32'h0);
        check("w256_queue_empty", q256.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
